// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the UART byte receiver.
// Imported by the receiver top; the state enum also names the FSM states.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rxState_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // Width of the bit-timing down-counter; it never holds more than CLKS_PER_BIT-1.
    function automatic int cntWidth(input int clksPerBit);
        return $clog2(clksPerBit);
    endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops load RESET_VAL on reset so the output starts at a known line level.
module bit_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1/8E1/8O1 serial receiver: recovers bytes from rxd with a fixed clocks-per-bit count.
// Good bytes appear on dout with a one-cycle dready_o; framing and parity faults only pulse a flag.
module uart_byte_receiver
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dready_o,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = cntWidth(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);

    logic          w_rxs;
    logic          w_expParity;
    rxState_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;
    logic          r_parBad;
    logic [7:0]    r_dout;
    logic          r_dready;
    logic          r_frameErr;
    logic          r_parityErr;

    bit_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rxSync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxs)
    );

    assign w_expParity = (^r_shift) ^ (PARITY_ODD != 0);

    // Counter reloads put every later sample near the middle of its bit, timed from the start-bit midpoint.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_parBad    <= 1'b0;
            r_dout      <= '0;
            r_dready    <= 1'b0;
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
        end else begin
            r_dready    <= 1'b0;
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_cnt   <= C_HALF;
                    end
                end
                START: begin
                    if (r_cnt == '0) begin
                        if (!w_rxs) begin
                            r_state  <= DATA;
                            r_cnt    <= C_FULL;
                            r_bitIdx <= '0;
                            r_parBad <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == '0) begin
                        r_shift  <= {w_rxs, r_shift[7:1]};
                        r_cnt    <= C_FULL;
                        r_bitIdx <= r_bitIdx + 3'd1;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (r_cnt == '0) begin
                        r_parBad <= (w_rxs != w_expParity);
                        r_cnt    <= C_FULL;
                        r_state  <= STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                STOP: begin
                    // A low stop bit outranks a parity fault; the line must then go high before re-arming.
                    if (r_cnt == '0) begin
                        if (w_rxs) begin
                            if (r_parBad) begin
                                r_parityErr <= 1'b1;
                            end else begin
                                r_dout   <= r_shift;
                                r_dready <= 1'b1;
                            end
                            r_state <= IDLE;
                        end else begin
                            r_frameErr <= 1'b1;
                            r_state    <= WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dready_o   = r_dready;
    assign frame_err  = r_frameErr;
    assign parity_err = r_parityErr;
    assign busy       = (r_state != IDLE);

endmodule
